// File: rtl/clz_unit.sv
// Iterative count-leading-zeros / count-leading-ones unit for the EX stage.
// Optional macro CLZ_ZERO_FAST_EN: an all-zero working word finishes at accept.
module clz_unit #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  localparam int NWIN = 32 / STEP;
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     x;
  logic [5:0]      cnt;
  logic [WW-1:0]   win;

  logic [STEP-1:0] window;
  logic            win_zero;
  logic [5:0]      win_lz;
  logic [5:0]      lz_sum;
  logic            last_win;
  logic [31:0]     opnd;

  // Handshake: start is taken on an edge where ready=1 (IDLE or DONE);
  // done is a one-cycle pulse and result is valid from that cycle until the next done.
  assign opnd      = op ? ~src : src;
  assign window    = x[31 -: STEP];
  assign win_zero  = (window == '0);
  assign last_win  = (win == WW'(NWIN - 1));
  assign lz_sum    = cnt + win_lz;
  assign dbg_state = state;

  // Leading zeros inside the current window; the highest set bit wins.
  always_comb begin
    win_lz = 6'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (window[i]) win_lz = 6'(STEP - 1 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      x      <= '0;
      cnt    <= '0;
      win    <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            x   <= opnd;
            cnt <= '0;
            win <= '0;
`ifdef CLZ_ZERO_FAST_EN
            if (opnd == 32'd0) begin
              result <= 32'd32;
              state  <= S_DONE;
              done   <= 1'b1;
            end else begin
              state <= S_SCAN;
              ready <= 1'b0;
              busy  <= 1'b1;
            end
`else
            state <= S_SCAN;
            ready <= 1'b0;
            busy  <= 1'b1;
`endif
          end
        end
        S_SCAN: begin
          if (win_zero) begin
            cnt <= cnt + 6'(STEP);
            x   <= x << STEP;
            win <= win + 1'b1;
            // Running off the last window means the whole word was zero.
            if (last_win) begin
              result <= 32'd32;
              state  <= S_DONE;
              ready  <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            result <= {26'd0, lz_sum};
            state  <= S_DONE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
